// File: rtl/dot_matrix_pkg.sv
// dot_matrix_pkg
//   Shared constants and types for the 8x8 LED dot matrix driver.
//   DM_ROWS/DM_COLS : matrix geometry
//   DM_ROW_W        : width of a row index
//   dm_state_t      : scan FSM state (DRIVE, BLANK)
//   dm_row_t        : one row of pixels, bit i = column i, 1 = lit
package dot_matrix_pkg;

   localparam int DM_ROWS  = 8;
   localparam int DM_COLS  = 8;
   localparam int DM_ROW_W = 3;

   typedef enum logic {
      ST_DRIVE = 1'b0,
      ST_BLANK = 1'b1
   } dm_state_t;

   typedef logic [DM_COLS-1:0] dm_row_t;

   // One-hot, active-low select pattern for a row.
   function automatic dm_row_t row_select(input logic [DM_ROW_W-1:0] row);
      return ~(dm_row_t'(1) << row);
   endfunction

endpackage

// File: rtl/dot_matrix_driver_scanner.sv
// dot_row_scanner
//   Row scan sequencer: hold counter, row index and DRIVE/BLANK FSM.
//   Parameter ROW_HOLD : cycles each row is driven (1..255).
//   Macro DOT_MATRIX_GHOST_BLANK_EN : when defined, a one-cycle BLANK
//   follows every row; otherwise rows change back-to-back.
//   Ports:
//     clock, reset : scan clock, synchronous active-high reset
//     row_idx      : row shown in the coming cycle
//     drive_en     : coming cycle is a DRIVE cycle
//     frame_end    : coming cycle is the last cycle of the frame
module dot_row_scanner
   import dot_matrix_pkg::*;
#(
   parameter int unsigned ROW_HOLD = 2
) (
   input  logic                clock,
   input  logic                reset,
   output logic [DM_ROW_W-1:0] row_idx,
   output logic                drive_en,
   output logic                frame_end
);

   localparam logic [7:0] HOLD_LAST = 8'(ROW_HOLD - 1);
   localparam logic [DM_ROW_W-1:0] LAST_ROW = DM_ROW_W'(DM_ROWS - 1);

   dm_state_t             state_q, state_d;
   logic [DM_ROW_W-1:0]   row_q, row_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  run_q;

   // The outputs describe the *next* cycle so the top level can register
   // them and still show row 0 on the first cycle after reset releases.
   always_comb begin
      state_d = ST_DRIVE;
      row_d   = row_q;
      cnt_d   = '0;
      if (!run_q) begin
         row_d = '0;
      end else begin
         case (state_q)
            ST_DRIVE: begin
               if (cnt_q == HOLD_LAST) begin
`ifdef DOT_MATRIX_GHOST_BLANK_EN
                  state_d = ST_BLANK;
`else
                  row_d = row_q + DM_ROW_W'(1);
`endif
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            ST_BLANK: row_d = row_q + DM_ROW_W'(1);
            default:  row_d = '0;
         endcase
      end
   end

   assign row_idx  = row_d;
   assign drive_en = (state_d == ST_DRIVE);
`ifdef DOT_MATRIX_GHOST_BLANK_EN
   assign frame_end = (state_d == ST_BLANK) && (row_d == LAST_ROW);
`else
   assign frame_end = (state_d == ST_DRIVE) && (row_d == LAST_ROW) &&
                      (cnt_d == HOLD_LAST);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_DRIVE;
         row_q   <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         run_q   <= 1'b1;
      end
   end

endmodule

// File: rtl/dot_matrix_driver.sv
// dot_matrix_driver
//   Double-buffered 8x8 LED matrix row-scan driver. Writes go to a back
//   buffer; a commit swaps it into view at the next frame end.
//   Macro DOT_MATRIX_GHOST_BLANK_EN : insert one blank cycle after each row.
//   Ports:
//     clock, reset        : scan clock, synchronous active-high reset
//     wr_valid/wr_ready   : back-buffer row write handshake
//     wr_row, wr_data     : row index and pixels (bit i = column i)
//     commit              : request swap at the next frame end
//     frame_done          : pulse on the last cycle of each frame
//     dot_row             : one-hot active-low row select
//     dot_col             : active-high column data
module dot_matrix_driver
   import dot_matrix_pkg::*;
#(
   parameter int unsigned ROW_HOLD = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [DM_ROW_W-1:0] wr_row,
   input  logic [DM_COLS-1:0]  wr_data,
   input  logic                commit,
   output logic                frame_done,
   output logic [DM_ROWS-1:0]  dot_row,
   output logic [DM_COLS-1:0]  dot_col
);

   dm_row_t             front [DM_ROWS];
   dm_row_t             back  [DM_ROWS];
   logic                pending_q, pending_d;
   logic                swap, wr_fire;
   logic [DM_ROW_W-1:0] row_idx;
   logic                drive_en, frame_end;

   dot_row_scanner #(.ROW_HOLD(ROW_HOLD)) u_scanner (
      .clock     (clock),
      .reset     (reset),
      .row_idx   (row_idx),
      .drive_en  (drive_en),
      .frame_end (frame_end)
   );

   // frame_done marks the current cycle as frame end.
   assign swap    = frame_done & pending_q;
   assign wr_fire = wr_valid & wr_ready;

   always_comb begin
      pending_d = pending_q;
      if (swap)
         pending_d = 1'b0;
      else if (commit)
         pending_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < DM_ROWS; i++) begin
            front[i] <= '0;
            back[i]  <= '0;
         end
         pending_q  <= 1'b0;
         wr_ready   <= 1'b0;
         frame_done <= 1'b0;
         dot_row    <= '1;
         dot_col    <= '0;
      end else begin
         if (wr_fire)
            back[wr_row] <= wr_data;
         if (swap)
            for (int unsigned i = 0; i < DM_ROWS; i++)
               front[i] <= back[i];
         pending_q  <= pending_d;
         wr_ready   <= ~pending_d;
         frame_done <= frame_end;
         dot_row    <= drive_en ? row_select(row_idx) : '1;
         // Front is being replaced on a swap edge, so read the new data
         // straight from the back buffer for the first row-0 cycle.
         dot_col    <= drive_en ? (swap ? back[row_idx] : front[row_idx]) : '0;
      end
   end

endmodule

// File: tb/tb_dot_matrix_driver.sv
// tb_dot_matrix_driver
//   Directed self-checking bench for dot_matrix_driver with ROW_HOLD=2.
//   Expectations follow the DOT_MATRIX_GHOST_BLANK_EN setting of the build.
module tb_dot_matrix_driver;

`ifdef DOT_MATRIX_GHOST_BLANK_EN
   localparam int FL = 24;
   logic [7:0] scan_exp [FL] = '{
      8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFF, 8'hFB, 8'hFB,
      8'hFF, 8'hF7, 8'hF7, 8'hFF, 8'hEF, 8'hEF, 8'hFF, 8'hDF,
      8'hDF, 8'hFF, 8'hBF, 8'hBF, 8'hFF, 8'h7F, 8'h7F, 8'hFF};
`else
   localparam int FL = 16;
   logic [7:0] scan_exp [FL] = '{
      8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7,
      8'hEF, 8'hEF, 8'hDF, 8'hDF, 8'hBF, 8'hBF, 8'h7F, 8'h7F};
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic       commit;
   logic       frame_done;
   logic [7:0] dot_row;
   logic [7:0] dot_col;

   int errors = 0;
   int checks = 0;

   dot_matrix_driver #(.ROW_HOLD(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_row     (wr_row),
      .wr_data    (wr_data),
      .commit     (commit),
      .frame_done (frame_done),
      .dot_row    (dot_row),
      .dot_col    (dot_col)
   );

   always #5 clock = ~clock;

   // Outputs are observed and inputs changed on the falling edge.
   task automatic tick();
      @(negedge clock);
   endtask

   // Leaves the bench at cycle 1: the first DRIVE cycle after reset.
   task automatic do_reset();
      wr_valid = 1'b0;
      commit   = 1'b0;
      reset    = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_valid = 1'b0; commit = 1'b0; wr_row = '0; wr_data = '0;
      repeat (3) tick();
      checks++; if (dot_row !== 8'hFF) begin errors++; $display("FAIL reset_row got %h expected ff", dot_row); end
      checks++; if (dot_col !== 8'h00) begin errors++; $display("FAIL reset_col got %h expected 00", dot_col); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", wr_ready); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fdone got %b expected 0", frame_done); end
      reset = 1'b0;
      tick();
      checks++; if (dot_row !== 8'hFE) begin errors++; $display("FAIL first_row got %h expected fe", dot_row); end
      checks++; if (dot_col !== 8'h00) begin errors++; $display("FAIL first_col got %h expected 00", dot_col); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL first_ready got %b expected 1", wr_ready); end
   endtask

   task automatic test_scan_order();
      do_reset();
      for (int c = 1; c <= FL + 1; c++) begin
         int  k = (c - 1) % FL;
         logic exp_fd = (c == FL);
         checks++; if (dot_row !== scan_exp[k]) begin errors++; $display("FAIL scan_row c=%0d got %h expected %h", c, dot_row, scan_exp[k]); end
         checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL scan_fdone c=%0d got %b expected %b", c, frame_done, exp_fd); end
         checks++; if (dot_col !== 8'h00) begin errors++; $display("FAIL scan_col c=%0d got %h expected 00", c, dot_col); end
         tick();
      end
   endtask

   task automatic test_commit();
      do_reset();
      for (int c = 1; c <= 2 * FL; c++) begin
         int   k = (c - 1) % FL;
         logic exp_rdy = (c <= 5) || (c > FL);
         logic [7:0] exp_col = (c > FL && scan_exp[k] == 8'hF7) ? 8'hA5 : 8'h00;
         checks++; if (wr_ready !== exp_rdy) begin errors++; $display("FAIL commit_ready c=%0d got %b expected %b", c, wr_ready, exp_rdy); end
         checks++; if (dot_col !== exp_col) begin errors++; $display("FAIL commit_col c=%0d got %h expected %h", c, dot_col, exp_col); end
         wr_valid = (c == 2); wr_row = 3'd3; wr_data = 8'hA5;
         commit   = (c == 5);
         tick();
      end
      wr_valid = 1'b0; commit = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 1; c <= 3 * FL; c++) begin
         int   k = (c - 1) % FL;
         logic [7:0] exp_col = 8'h00;
         if (c > FL && scan_exp[k] == 8'h7F) exp_col = 8'h81;
         if (c > 2 * FL && scan_exp[k] == 8'hFE) exp_col = 8'h3C;
         if (c == 3 || c == FL + 2) begin
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wc_ready c=%0d got %b expected 1", c, wr_ready); end
         end
         if (c == 4 || c == FL + 3) begin
            checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL wc_drop c=%0d got %b expected 0", c, wr_ready); end
         end
         checks++; if (dot_col !== exp_col) begin errors++; $display("FAIL wc_col c=%0d got %h expected %h", c, dot_col, exp_col); end
         wr_valid = (c == 3) || (c == FL + 2);
         wr_row   = (c == 3) ? 3'd7 : 3'd0;
         wr_data  = (c == 3) ? 8'h81 : 8'h3C;
         commit   = (c == 3) || (c == FL + 2);
         tick();
      end
      wr_valid = 1'b0; commit = 1'b0;
   endtask

   task automatic test_commit_on_frame_end();
      do_reset();
      for (int c = 1; c <= 4 * FL; c++) begin
         int   k = (c - 1) % FL;
         logic [7:0] exp_col = (c > 2 * FL && scan_exp[k] == 8'hFD) ? 8'h5A : 8'h00;
         if (c == FL) begin
            checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL fe_fdone got %b expected 1", frame_done); end
         end
         if (c == FL + 1 || c == 2 * FL) begin
            checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fe_pending c=%0d got %b expected 0", c, wr_ready); end
         end
         if (c == 2 * FL + 1) begin
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL fe_release got %b expected 1", wr_ready); end
         end
         checks++; if (dot_col !== exp_col) begin errors++; $display("FAIL fe_col c=%0d got %h expected %h", c, dot_col, exp_col); end
         // Row 1 = 5A; commit on frame end; write while not ready (dropped);
         // second commit while pending; later uncommitted overwrite.
         wr_valid = (c == 2) || (c == FL + 3) || (c == 2 * FL + 2);
         wr_row   = 3'd1;
         wr_data  = (c == 2) ? 8'h5A : ((c == FL + 3) ? 8'h11 : 8'hFF);
         commit   = (c == FL) || (c == FL + 5);
         tick();
      end
      wr_valid = 1'b0; commit = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      for (int c = 1; c <= 12 + 2 * FL; c++) begin
         if (c == 11 || c == 12) begin
            checks++; if (dot_row !== 8'hFF) begin errors++; $display("FAIL mid_rst_row c=%0d got %h expected ff", c, dot_row); end
            checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready c=%0d got %b expected 0", c, wr_ready); end
         end
         if (c >= 13) begin
            int k = (c - 13) % FL;
            checks++; if (dot_row !== scan_exp[k]) begin errors++; $display("FAIL mid_row c=%0d got %h expected %h", c, dot_row, scan_exp[k]); end
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL mid_ready c=%0d got %b expected 1", c, wr_ready); end
         end
         checks++; if (dot_col !== 8'h00) begin errors++; $display("FAIL mid_col c=%0d got %h expected 00", c, dot_col); end
         wr_valid = (c == 2); wr_row = 3'd2; wr_data = 8'hC3;
         commit   = (c == 3);
         reset    = (c == 10) || (c == 11);
         tick();
      end
      wr_valid = 1'b0; commit = 1'b0; reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_commit();
      test_back_to_back();
      test_commit_on_frame_end();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dot_matrix_driver.md
# dot_matrix_driver

Row-scanning driver for the 8x8 LED dot matrix: holds a double-buffered 8x8 frame and multiplexes it onto `dot_row`/`dot_col` one row at a time. The row/column scan mirrors the keypad scanner but runs in the opposite direction: rows are strobed and columns are driven rather than sampled. Game logic writes rows through a valid/ready port into a back buffer. A commit request swaps that buffer into view at the next frame boundary, so a partially written frame is never displayed. The block is instanced in the top level and clocked from the 10 kHz divided clock.

## Interface
- `ROW_HOLD`, default 2: number of cycles each row is driven; legal range 1..255.
- `clock` input 1: scan clock (10 kHz divided clock).
- `reset` input 1: synchronous, active-high.
- `wr_valid` input 1: a row write is offered.
- `wr_ready` output 1: the back buffer accepts a write this cycle.
- `wr_row` input 3: index of the back-buffer row being written.
- `wr_data` input 8: row pixels; bit i is column i, 1 = lit.
- `commit` input 1: one-cycle request to show the back buffer at the next frame end.
- `frame_done` output 1: one-cycle pulse on the last cycle of row 7's period.
- `dot_row` output 8: one-hot, active-low row select.
- `dot_col` output 8: active-high column data for the selected row.

## Operation
- All outputs are registered.
- Reset values:
  - `dot_row` = 8'hFF, `dot_col` = 8'h00, `frame_done` = 0, `wr_ready` = 0.
  - Front and back buffers are all zero; row index = 0; hold counter = 0; commit-pending flag = 0.
- Scan FSM states:
  - DRIVE: `dot_row` = ~(1<<row), `dot_col` = front[row]. Stay for ROW_HOLD cycles, then go to BLANK (or to the next row directly when blanking is compiled out).
  - BLANK: `dot_row` = 8'hFF, `dot_col` = 0 for one cycle, then DRIVE with row+1.
- The row index wraps 7 -> 0.
- Frame end is the last cycle of row 7's period: the BLANK cycle when blanking is compiled in, otherwise the last DRIVE cycle.
  - `frame_done` = 1 on that cycle.
  - If commit-pending is set: front <= back on that cycle, and commit-pending clears.
- Write port:
  - A transfer happens when `wr_valid` & `wr_ready`: back[`wr_row`] <= `wr_data`.
  - `wr_ready` = ~reset_last_cycle & ~commit_pending.
- Commit:
  - `commit` while commit-pending is already set is ignored (no queuing).
  - A write and `commit` in the same cycle: the write is accepted and belongs to the committed frame; `wr_ready` drops on the next cycle.
  - `commit` on a frame-end cycle sets pending for the following frame end; it does not swap on that cycle.
- After a swap, the back buffer keeps its contents, so incremental updates do not require rewriting all 8 rows.
- Reset asserted mid-frame: everything returns to reset values on the next edge. A pending commit is dropped.

## Timing
- First DRIVE cycle (row 0) is the first cycle after `reset` deasserts; `wr_ready` = 1 from that same cycle.
- Frame length = 8*(ROW_HOLD+1) cycles with blanking, 8*ROW_HOLD without. With ROW_HOLD=2: 24 and 16 cycles.
- Swap latency: new front data appears on `dot_col` at the first row-0 DRIVE cycle after the frame-end cycle.
- Maximum wait from `commit` to display is one full frame plus one cycle.
- `wr_ready` returns to 1 on the cycle after the swap.

## Configuration
- `DOT_MATRIX_GHOST_BLANK_EN`:
  - Defined: the one-cycle BLANK state is inserted after every row (anti-ghosting).
  - Undefined: BLANK is removed, rows change back-to-back, and frame end is the last DRIVE cycle of row 7.

## Structure
- Shared package `dot_matrix_pkg`:
  - Constants `DM_ROWS`=8, `DM_COLS`=8, `DM_ROW_W`=3.
  - Scan-state enum (DRIVE, BLANK).
  - `dm_row_t` typedef (8-bit row pixels).
- Sub-module `dot_row_scanner` holds the hold counter, row index and FSM. It emits `row_idx`, `drive_en` and `frame_end`.
- The top level holds the buffers, commit logic and output registers.

## Test plan
All scenarios use ROW_HOLD=2 with blanking compiled in unless stated.
- **Reset:** hold `reset` 3 cycles -> `dot_row`=8'hFF, `dot_col`=0, `wr_ready`=0. Release -> next cycle `dot_row`=8'hFE, `dot_col`=0, `wr_ready`=1.
- **Scan order:** run 24 cycles with empty buffers -> `dot_row` sequence FE,FE,FF,FD,FD,FF,...,7F,7F,FF. `frame_done` is high only on cycle 24.
- **Commit:** write row 3 = 8'hA5, pulse `commit` at cycle 5 -> `wr_ready` low until the frame-end swap. Row 3 shows `dot_col`=8'hA5 from the next frame on; all other rows show 0.
- **Write and commit together:** `wr_valid` with row 7 = 8'h81 in the same cycle as `commit` -> write accepted. Next frame shows 8'h81 on `dot_row`=8'h7F.
- **Commit on frame end:** `commit` on a frame-end cycle -> no swap that frame; swap at the following frame end. A second `commit` while pending has no extra effect.
- **Blanking compiled out:** frame is 16 cycles, no 8'hFF gaps. Reset asserted mid-frame with a commit pending -> buffers are cleared and no swap occurs afterwards.
